// File: rtl/fifo_pkg.sv
// fifo_pkg: shared data width, uart transmitter state encoding and 8N1 frame levels
package fifo_pkg;
  localparam int DEF_DATA_W = 8;
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: per-bit cycle counter with synchronous clear and last-cycle tick
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] cnt;
  assign tick = cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk)
    cnt <= (!reset || clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from a registered-read fifo and sends them as 8N1 uart frames
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_dout,
  output logic              fifo_rd_en,
  output logic              tx,
  output logic              busy,
  output logic [CNT_W-1:0]  frames_sent
);
  localparam int BW = DATA_W > 1 ? $clog2(DATA_W) : 1;
  state_t state, nxt;
  logic [DATA_W-1:0] shift;
  logic [BW-1:0] bit_cnt;
  logic tick, go;
  assign go = tx_en && !fifo_empty;
  assign fifo_rd_en = state == FETCH;
  assign busy = state != IDLE;
  uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk  (clk),
    .reset(reset),
    .clr  (nxt != state),
    .tick (tick)
  );
  always_ff @(posedge clk)
    state <= !reset ? IDLE : nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = go ? FETCH : IDLE;
      FETCH:   nxt = LOAD;
      LOAD:    nxt = START;
      START:   nxt = tick ? DATA : START;
      DATA:    nxt = (tick && bit_cnt == BW'(DATA_W - 1)) ? STOP : DATA;
      STOP:    nxt = tick ? (go ? FETCH : IDLE) : STOP;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx <= STOP_BIT;
      shift <= '0;
      bit_cnt <= '0;
      frames_sent <= '0;
    end else begin
      tx <= state == START ? START_BIT : state == DATA ? shift[0] : STOP_BIT;
      if (state == LOAD) begin
        shift <= fifo_dout;
        bit_cnt <= '0;
      end else if (state == DATA && tick) begin
        shift <= shift >> 1;
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (state == STOP && tick)
        frames_sent <= frames_sent + 1'b1;
    end
  end
endmodule

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
Read-side consumer for the team's 8-bit synchronous FIFO. It pops bytes through the FIFO's rd_en/empty/d_out interface and serializes each byte onto a UART-style line as 8N1: one start bit, 8 data bits LSB first, one stop bit. It sits between the FIFO output and the pad/debug serial port and drains the FIFO whenever it is enabled and the FIFO is non-empty.

Parameters:
DATA_W, 8, data bits per frame; must match FIFO data width.
CLKS_PER_BIT, 16, clk cycles per serial bit; legal range >= 2.
CNT_W, 16, width of the frames_sent counter.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous active-low reset.
tx_en  input  1  allows a new frame to start; sampled only in IDLE.
fifo_empty  input  1  FIFO empty flag.
fifo_dout  input  DATA_W  FIFO read data; valid the cycle after fifo_rd_en is high (registered read).
fifo_rd_en  output  1  single-cycle pop strobe to the FIFO.
tx  output  1  serial line; idles high.
busy  output  1  high from FETCH through STOP inclusive.
frames_sent  output  CNT_W  count of completed frames; wraps.

Behaviour:
- Reset: one clock and the reset port are fixed. reset is synchronous and active-low. While reset=0 at a clk edge: state=IDLE, tx=1, fifo_rd_en=0, busy=0, frames_sent=0, shift register=0, baud and bit counters=0.
- States:
  - IDLE: tx=1. If tx_en=1 and fifo_empty=0, go to FETCH.
  - FETCH: fifo_rd_en=1 for exactly this one cycle. Go to LOAD.
  - LOAD: capture fifo_dout into the shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: tx = shift[0]. Shift right after each CLKS_PER_BIT cycles; bit counter runs 0..DATA_W-1. After bit DATA_W-1, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. On the last cycle, frames_sent increments and the next state is chosen as in IDLE: FETCH if tx_en=1 and fifo_empty=0, else IDLE.
- Latency:
  - FIFO non-empty in IDLE: rd_en asserts 1 cycle later, and tx falls 3 cycles after the IDLE decision edge.
  - Frame length on the line is (DATA_W+2)*CLKS_PER_BIT cycles.
  - Back-to-back frames have a gap of exactly 2 cycles of tx=1 (FETCH + LOAD) beyond the stop bit.
- Baud counter: counts 0..CLKS_PER_BIT-1 and clears on every state change. No fractional rate.
- Boundaries:
  - fifo_rd_en is never asserted while fifo_empty=1 at the same edge. FETCH is entered only on an observed non-empty.
  - Exactly one pop per frame.
  - tx_en=0 mid-frame does not abort; the frame completes and the block then stays in IDLE.
  - fifo_empty changing mid-frame is ignored until the STOP/IDLE decision.
  - frames_sent wraps from 2^CNT_W-1 to 0.
  - Reset mid-frame: tx returns to 1 at that edge and the popped byte is discarded, not re-read. frames_sent is not incremented.
  - tx is driven from a register, so there are no combinational glitches.

Decomposition:
- Shared package (fifo_pkg): DATA_W default, the state encoding constants (IDLE, FETCH, LOAD, START, DATA, STOP as 3-bit), and the UART frame constants (start=0, stop=1).
- One natural sub-module: uart_baud_tick. It is a CLKS_PER_BIT counter with clear input and a last-cycle tick output, and is instantiated once.
- The FSM, shift register and frame counter stay in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles with fifo_empty=0 and tx_en=1 -> tx=1, fifo_rd_en=0, busy=0, frames_sent=0 throughout. First fifo_rd_en pulse appears 1 cycle after reset releases.
- Single byte: CLKS_PER_BIT=4, FIFO holding 0xB1 -> one rd_en pulse; tx sequence (4 cycles each) is 0,1,0,0,0,1,1,0,1,1; frames_sent=1; busy low afterwards.
- Back-to-back: FIFO holding 0xB1 then 0xFD -> two rd_en pulses 42 cycles apart; second frame data bits read 1,0,1,1,1,1,1,1; frames_sent=2; then IDLE with fifo_empty=1.
- Empty/enable gating: fifo_empty=1 for 50 cycles -> no rd_en pulses, tx=1. Then tx_en=0 with fifo_empty=0 -> still no pop; raising tx_en starts a frame within 1 cycle.
- Mid-frame events: drop tx_en during DATA -> frame completes, no further pop. Assert reset=0 during bit 3 -> tx=1 at that edge, frames_sent unchanged, next frame after release starts with a new pop.
- Wrap: CNT_W=2, send 5 frames -> frames_sent reads 1,2,3,0,1.
